moving_avg_filter: RTL and testbench
====================================

MOVING_AVG_FILTER -- requirements
Module: moving_avg_filter

Interface
REQ-001 The block SHALL have parameter D_SIZE, default 8, sample and result width in bits.
REQ-002 The block SHALL have parameter WIN_LOG2, default 2, log2 of the window length N = 2^WIN_LOG2 (legal range 1..4).
REQ-003 The block SHALL have port i_w_clk  input  1  write-domain clock, with all logic on its rising edge.
REQ-004 The block SHALL have port i_w_rstn  input  1  reset (asynchronous, active-low); the clock is i_w_clk.
REQ-005 The block SHALL have port i_valid  input  1  input sample qualifier.
REQ-006 The block SHALL have port i_sample  input  D_SIZE  unsigned input sample.
REQ-007 The block SHALL have port i_clear  input  1  synchronous flush of window and pending result.
REQ-008 The block SHALL have port i_fifo_full  input  1  full flag from the downstream async FIFO write side.
REQ-009 The block SHALL have port o_ready  output  1  sample accept indication.
REQ-010 The block SHALL have port o_w_inc  output  1  FIFO write strobe, one cycle per result.
REQ-011 The block SHALL have port o_w_data  output  D_SIZE  averaged result to the FIFO write data bus.
REQ-012 The block SHALL have port o_primed  output  1  window full; results are being produced.

Function
REQ-013 A sample SHALL be accepted on a rising edge where i_valid=1, o_ready=1 and i_clear=0.
REQ-014 The block SHALL hold the last N accepted samples in a circular buffer with a WIN_LOG2-bit write index that wraps from N-1 to 0.
REQ-015 The block SHALL keep a running sum of width D_SIZE+WIN_LOG2 and update it on each acceptance as sum + new - oldest; a stored oldest entry of 0 applies while filling.
REQ-016 The FSM SHALL have states FILL and RUN; FILL SHALL move to RUN on the edge that accepts the Nth sample after reset or clear; RUN SHALL persist until reset or i_clear.
REQ-017 o_primed SHALL be 1 exactly when the FSM is in RUN.
REQ-018 On each acceptance that leaves the FSM in RUN, the block SHALL load the updated sum >> WIN_LOG2 into an output register and set pending=1 on the same edge, giving a latency of 1 cycle.
REQ-019 o_w_inc SHALL equal pending AND NOT i_fifo_full.
REQ-020 o_w_data SHALL equal the output register and SHALL be held stable while pending=1.
REQ-021 o_ready SHALL equal NOT pending OR NOT i_fifo_full, so that a full FIFO with a result pending stalls input.
REQ-022 pending SHALL clear on an edge with o_w_inc=1 and no new result load.
REQ-023 If a drain and a new load occur on the same edge, pending SHALL stay 1 and the output register SHALL take the new result, sustaining 1 result per cycle.
REQ-024 i_clear=1 SHALL take priority over i_valid, and on that edge SHALL zero the buffer, sum and index, set FILL, clear pending, and produce no o_w_inc on the following cycle.
REQ-025 No result SHALL ever be dropped or duplicated while i_fifo_full toggles.

Reset
REQ-026 While i_w_rstn=0, the block SHALL zero the buffer, sum, index, output register and pending, and set the FSM to FILL.
REQ-027 While i_w_rstn=0, outputs SHALL be o_w_inc=0, o_w_data=0, o_primed=0 and o_ready=1.
REQ-028 A reset asserted mid-operation SHALL discard any pending result and the partial window, with no o_w_inc after reset deassertion until N new samples are accepted.

Configuration
REQ-029 The block SHALL support the macro MAF_ROUND_EN.
REQ-030 With MAF_ROUND_EN defined, the result SHALL be (sum + 2^(WIN_LOG2-1)) >> WIN_LOG2, which needs no extra width because the maximum is below N*2^D_SIZE.
REQ-031 Without MAF_ROUND_EN defined, the result SHALL be sum >> WIN_LOG2, truncating.
REQ-032 The macro SHALL not affect latency, handshake or state behaviour.

Verification (D_SIZE=8, WIN_LOG2=2)
REQ-033 Scenario warm-up: samples 4, 8, 12, 16 with i_fifo_full=0 -> no o_w_inc for the first three; one cycle after the 4th, o_w_inc=1 and o_w_data=10, and o_primed=1.
REQ-034 Scenario steady state: continue with samples 20, 24 -> results 14 and 18 on consecutive cycles, one o_w_inc each.
REQ-035 Scenario rounding: samples 10, 10, 11, 11 (sum 42) -> o_w_data=11 with MAF_ROUND_EN and 10 without it.
REQ-036 Scenario backpressure: i_fifo_full=1 during warm-up with 4 samples -> after the result, o_ready=0, o_w_inc=0 and o_w_data held; release full -> exactly one o_w_inc, then o_ready=1.
REQ-037 Scenario maximum value: four samples of 255 -> o_w_data=255 in both macro builds, with no sum overflow.
REQ-038 Scenario clear and reset: i_clear pulsed after 2 samples, then 3 samples -> no output; i_w_rstn pulsed low with a result pending -> o_w_inc=0 and the next output only after 4 new samples.

Source files
------------

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: N = 2^WIN_LOG2 tap moving average feeding an async FIFO
// write port. The sum is maintained incrementally from a circular buffer of
// the last N samples. One result is produced per accepted sample once the
// window is full. A result waiting on a full FIFO stalls the input.
// Optional build macro MAF_ROUND_EN: round-half-up instead of truncating.
module moving_avg_filter #(
   parameter int D_SIZE   = 8,
   parameter int WIN_LOG2 = 2
) (
   input  logic              i_w_clk,
   input  logic              i_w_rstn,
   input  logic              i_valid,
   input  logic [D_SIZE-1:0] i_sample,
   input  logic              i_clear,
   input  logic              i_fifo_full,
   output logic              o_ready,
   output logic              o_w_inc,
   output logic [D_SIZE-1:0] o_w_data,
   output logic              o_primed
);

   localparam int N  = 1 << WIN_LOG2;
   localparam int SW = D_SIZE + WIN_LOG2;

   typedef enum logic {FILL, RUN} state_t;

   logic [N-1:0][D_SIZE-1:0] win_q, win_d;
   logic [SW-1:0]            sum_q, sum_d;
   logic [SW-1:0]            res_sum;
   logic [WIN_LOG2-1:0]      idx_q, idx_d;
   state_t                   state_q, state_d;
   logic [D_SIZE-1:0]        out_q, out_d;
   logic                     pend_q, pend_d;
   logic                     accept;
   logic                     load;

   // Handshake: a result stuck behind a full FIFO blocks new samples.
   assign o_ready  = ~pend_q | ~i_fifo_full;
   assign o_w_inc  = pend_q & ~i_fifo_full;
   assign o_w_data = out_q;
   assign o_primed = (state_q == RUN);

   assign accept = i_valid & o_ready & ~i_clear;

   // Next-state: window update, running sum, FSM and output register.
   always_comb begin
      win_d   = win_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      state_d = state_q;
      out_d   = out_q;
      pend_d  = pend_q;
      load    = 1'b0;
      // Zeroed slots during FILL make "subtract the oldest" a no-op.
      // Modular arithmetic in SW bits is exact since the true sum always fits.
      res_sum = sum_q + {{WIN_LOG2{1'b0}}, i_sample} - {{WIN_LOG2{1'b0}}, win_q[idx_q]};
`ifdef MAF_ROUND_EN
      // Max sum + N/2 stays below N*2^D_SIZE, so no extra bit is needed.
      res_sum = res_sum + SW'(N / 2);
`endif
      if (i_clear) begin
         win_d   = '0;
         sum_d   = '0;
         idx_d   = '0;
         state_d = FILL;
         pend_d  = 1'b0;
      end else begin
         // Drain first; a same-edge load below overrides it.
         if (o_w_inc)
            pend_d = 1'b0;
         if (accept) begin
            win_d[idx_q] = i_sample;
            sum_d        = sum_q + {{WIN_LOG2{1'b0}}, i_sample} - {{WIN_LOG2{1'b0}}, win_q[idx_q]};
            idx_d        = idx_q + WIN_LOG2'(1);
            if (state_q == RUN || idx_q == WIN_LOG2'(N - 1)) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         if (load) begin
            out_d  = res_sum[SW-1:WIN_LOG2];
            pend_d = 1'b1;
         end
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge i_w_clk or negedge i_w_rstn) begin
      if (!i_w_rstn) begin
         win_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         state_q <= FILL;
         out_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         win_q   <= win_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         out_q   <= out_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Randomised + directed bench for moving_avg_filter (D_SIZE=8, WIN_LOG2=2).
// Reference: a queue holding the current window and a queue of results owed
// to the FIFO; outputs are checked every cycle half a period after the edge.
module tb_moving_avg_filter;

   localparam int D = 8;
   localparam int W = 2;
   localparam int N = 1 << W;

   logic         i_w_clk = 1'b0;
   logic         i_w_rstn = 1'b0;
   logic         i_valid = 1'b0;
   logic [D-1:0] i_sample = '0;
   logic         i_clear = 1'b0;
   logic         i_fifo_full = 1'b0;
   logic         o_ready, o_w_inc, o_primed;
   logic [D-1:0] o_w_data;

   int n_cmp = 0;
   int n_bad = 0;
   int win[$];
   int owe[$];

   moving_avg_filter #(.D_SIZE(D), .WIN_LOG2(W)) dut (
      .i_w_clk(i_w_clk), .i_w_rstn(i_w_rstn), .i_valid(i_valid),
      .i_sample(i_sample), .i_clear(i_clear), .i_fifo_full(i_fifo_full),
      .o_ready(o_ready), .o_w_inc(o_w_inc), .o_w_data(o_w_data),
      .o_primed(o_primed)
   );

   always #5 i_w_clk = ~i_w_clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int avg_of_window();
      int s = 0;
      foreach (win[i]) s += win[i];
`ifdef MAF_ROUND_EN
      s += N / 2;
`endif
      return s >> W;
   endfunction

   // One cycle: drive inputs after the falling edge, check, advance the model.
   task automatic cyc(input bit v, input int s, input bit c, input bit f);
      bit exp_rdy, exp_inc;
      @(negedge i_w_clk);
      i_valid = v; i_sample = D'(s); i_clear = c; i_fifo_full = f;
      #1;
      exp_inc = (owe.size() > 0) && !f;
      exp_rdy = (owe.size() == 0) || !f;
      chk("ready", int'(o_ready), int'(exp_rdy));
      chk("w_inc", int'(o_w_inc), int'(exp_inc));
      chk("primed", int'(o_primed), int'(win.size() == N));
      if (owe.size() > 0) chk("w_data", int'(o_w_data), owe[0]);
      if (exp_inc) void'(owe.pop_front());
      if (c) begin
         win.delete();
         owe.delete();
      end else if (v && exp_rdy) begin
         win.push_back(s);
         if (win.size() > N) void'(win.pop_front());
         if (win.size() == N) owe.push_back(avg_of_window());
      end
   endtask

   task automatic idle(input int n, input bit f);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, f);
   endtask

   task automatic do_reset();
      @(negedge i_w_clk);
      i_valid = 1'b0; i_clear = 1'b0; i_fifo_full = 1'b1;
      i_w_rstn = 1'b0;
      #1;
      chk("rst_inc", int'(o_w_inc), 0);
      chk("rst_data", int'(o_w_data), 0);
      chk("rst_primed", int'(o_primed), 0);
      chk("rst_ready", int'(o_ready), 1);
      win.delete();
      owe.delete();
      @(negedge i_w_clk);
      i_w_rstn = 1'b1;
   endtask

   initial begin
      do_reset();

      // Warm-up then steady state: 10, then 14, 18 back-to-back.
      cyc(1, 4, 0, 0); cyc(1, 8, 0, 0); cyc(1, 12, 0, 0); cyc(1, 16, 0, 0);
      cyc(1, 20, 0, 0); cyc(1, 24, 0, 0);
      idle(2, 0);

      // Rounding: sum 42 -> 11 rounded, 10 truncated.
      cyc(0, 0, 1, 0);
      cyc(1, 10, 0, 0); cyc(1, 10, 0, 0); cyc(1, 11, 0, 0); cyc(1, 11, 0, 0);
      idle(2, 0);

      // Backpressure during warm-up, with extra samples offered while stalled.
      cyc(0, 0, 1, 1);
      cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 6, 0, 1);
      cyc(1, 99, 0, 1); cyc(1, 99, 0, 1);
      idle(1, 0);
      idle(2, 0);

      // Maximum value: no overflow in either build.
      cyc(0, 0, 1, 0);
      for (int i = 0; i < N; i++) cyc(1, 255, 0, 0);
      idle(2, 0);

      // Clear after 2 samples, then 3 more: still no output.
      cyc(0, 0, 1, 0);
      cyc(1, 50, 0, 0); cyc(1, 60, 0, 0);
      cyc(1, 70, 1, 0);
      cyc(1, 5, 0, 0); cyc(1, 6, 0, 0); cyc(1, 7, 0, 0);
      idle(2, 0);

      // Reset with a result pending; output only after 4 fresh samples.
      cyc(1, 9, 0, 1);
      idle(1, 1);
      do_reset();
      cyc(1, 30, 0, 0); cyc(1, 31, 0, 0); cyc(1, 32, 0, 0);
      idle(2, 0);
      cyc(1, 33, 0, 0);
      idle(2, 0);

      // Random traffic with toggling full and occasional clears.
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
             $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4);
      idle(4, 0);
      chk("owed_drained", owe.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
